mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares a 4-input, WIDTH-bit select path between four requesters and forwards the granted requester's data downstream over a valid/ready handshake. It owns the 2-bit `sel` code and applies it to the data path. It sits between four independent producers and a single consumer. A grant is held for a burst of up to MAX_BURST accepted beats, or until the owner drops `req`, and is then rotated fairly.

## Interface
- `WIDTH`, 4: data width of each input and of `out`
- `MAX_BURST`, 4: max accepted beats per grant before forced release; legal range is ≥1
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  4  per-requester request; bit i corresponds to `in(i+1)`
- `in1`..`in4`  in  WIDTH each  requester data, sel codes 0..3
- `out_ready`  in  1  downstream accepts the beat this cycle
- `gnt`  out  4  one-hot grant, registered
- `sel`  out  2  current select code, registered
- `out`  out  WIDTH  data of the granted requester
- `out_valid`  out  1  beat on `out` is valid
- `busy`  out  1  a grant is active (state GRANT)

One clock (`clk`). Reset is asynchronous and active-low (`rst_n`).

## Operation
- FSM has two states: IDLE and GRANT.
- Registered state: state, `sel`, `gnt`, `last` (pointer to the previous winner), beat counter `cnt` (width $clog2(MAX_BURST+1)).
- Reset values: state=IDLE, `gnt`=0, `sel`=0, `last`=3, `cnt`=0. Consequently `out`=0, `out_valid`=0, `busy`=0.
- IDLE, `req`≠0:
  - Pick the winner by searching in order `last`+1, `last`+2, `last`+3, `last` (mod 4).
  - Next state GRANT; `sel` and `last` are set to the winner, `gnt`=1<<winner, `cnt`=0.
- IDLE, `req`=0: remain in IDLE.
- GRANT combinational outputs:
  - `out_valid` = `req[sel]`.
  - `out` = input selected by `sel`, or 0 when not in GRANT.
- A beat transfers when `out_valid` & `out_ready`. Each transfer increments `cnt`.
- Release: leave GRANT for IDLE, clear `gnt` and `cnt`, and keep `sel`, when either:
  - `req[sel]`=0, which releases immediately with no transfer that cycle; or
  - a transfer occurs while `cnt`==MAX_BURST−1.
- `out_ready` low in GRANT holds the grant and does not advance `cnt`.
- Requests from non-owners during GRANT are ignored until the next IDLE.
- A requester that just lost its grant has the lowest priority at the next arbitration. If it is the only requester, it wins again.

## Timing
- Latency from `req` to `gnt`: `req` sampled high in IDLE → `gnt`/`busy` high on the next edge; the first beat can transfer in that cycle.
- Every release inserts exactly one IDLE bubble cycle. A continuous single requester with MAX_BURST=4 therefore gets 4 beats per 5 cycles.
- `out` and `out_valid` are combinational from registered `sel`/state, `req`, and the inputs. There is no data pipeline stage.
- Reset mid-burst: everything clears asynchronously, and the first arbitration after reset starts from requester 0.
- `req` and `in*` must be stable and synchronous to `clk`.

## Structure
- Package `mux_arb_pkg` holds:
  - state enum {IDLE, GRANT};
  - `NUM_REQ`=4;
  - `SEL_W`=2.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs are `req`[3:0] and `last`[1:0]; outputs are `any` and `win`[1:0]. It is reused by other arbiters.
- The top level holds the FSM, the counter, and the data select.

## Test plan
- Reset then idle: `req`=0 for 10 cycles → `gnt`=0, `sel`=0, `out_valid`=0, `out`=0.
- Single requester `req`=0100, `in3`=4'hA, `out_ready`=1, MAX_BURST=4:
  - `gnt`=0100 and `sel`=2 one cycle later;
  - 4 beats of 4'hA;
  - 1 IDLE cycle, then re-granted to requester 2.
- All requesting (`req`=1111), `out_ready`=1 → grant order 0,1,2,3,0 with 4 beats each and one bubble between grants.
- Backpressure: requester 1 granted, `out_ready` low for 3 cycles → `gnt` held, `cnt` frozen, still exactly 4 transfers before release.
- Early drop: requester 0 granted, drops `req` after 2 beats → release that cycle with no third transfer; with `req`=1010 pending, the next `gnt`=0010.
- Async reset asserted mid-burst (requester 3, `cnt`=2) → outputs clear immediately; after release with `req`=1001, `gnt`=0001 first.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin select arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for mux_rr_arbiter; master is the arbiter side.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [WIDTH-1:0]   in3;
  logic [WIDTH-1:0]   in4;
  logic               out_ready;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               busy;

  modport master (
    input  req, in1, in2, in3, in4, out_ready,
    output gnt, sel, out, out_valid, busy
  );

  modport slave (
    output req, in1, in2, in3, in4, out_ready,
    input  gnt, sel, out, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first requester after `last`, wrapping, `last` itself lowest.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest to highest priority so the nearest requester after `last` wins.
  always_comb begin
    any = |req;
    win = last;
    idx = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a 4:1 select path; holds a grant for up to MAX_BURST beats.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.master bus
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, last_q, win;
  logic [NUM_REQ-1:0] gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               any, own_req, xfer, burst_end;

  rr_pick u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (any),
    .win  (win)
  );

  assign own_req   = bus.req[sel_q];
  assign xfer      = (state_q == GRANT) && own_req && bus.out_ready;
  assign burst_end = xfer && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any) state_d = GRANT;
      GRANT: if (!own_req || burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last resets to the top index so the first arbitration starts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      last_q <= SEL_W'(NUM_REQ - 1);
      gnt_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            sel_q  <= win;
            last_q <= win;
            gnt_q  <= NUM_REQ'(1) << win;
            cnt_q  <= '0;
          end
        end
        GRANT: begin
          if (state_d == IDLE) begin
            gnt_q <= '0;
            cnt_q <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.sel       = sel_q;
    bus.busy      = (state_q == GRANT);
    bus.out_valid = (state_q == GRANT) && own_req;
    bus.out       = '0;
    if (state_q == GRANT) begin
      unique case (sel_q)
        2'd0: bus.out = bus.in1;
        2'd1: bus.out = bus.in2;
        2'd2: bus.out = bus.in3;
        2'd3: bus.out = bus.in4;
        default: bus.out = '0;
      endcase
    end
  end

endmodule
